ysyx_22050710_sram_arbiter: RTL and testbench

//   N-channel SRAM-like bus arbiter. Merges the core's SRAM-like master ports (inst, data, future
//   DMA/cache refill) onto one shared SRAM-like port toward memory/AXI bridge. Tracks
//   in-flight requests in an ID FIFO so in-order data_ok/rdata return to the issuing channel.

---
 rtl/ysyx_22050710_sram_arbiter_pkg.sv | 22 ++
 rtl/ysyx_22050710_sram_arbiter_id_fifo.sv | 54 +++++
 rtl/ysyx_22050710_sram_arbiter.sv | 139 +++++++++++++
 tb/tb_ysyx_22050710_sram_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050710_sram_arbiter_pkg.sv
// Shared types and helpers for the SRAM-like bus arbiter.
// Size encodings, arbiter lock-state enum and channel-id width helper.
package ysyx_22050710_sram_arbiter_pkg;

  typedef enum logic [1:0] {
    SRAM_SIZE_1B = 2'd0,
    SRAM_SIZE_2B = 2'd1,
    SRAM_SIZE_4B = 2'd2,
    SRAM_SIZE_8B = 2'd3
  } sram_size_e;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Width of a channel index; kept at least one bit wide.
  function automatic int unsigned ch_id_wd(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/ysyx_22050710_sram_arbiter_id_fifo.sv
// In-flight request ID FIFO: remembers which channel issued each accepted request
// so responses can be routed back in order.
module ysyx_22050710_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/ysyx_22050710_sram_arbiter.sv
// N-channel SRAM-like arbiter: merges upstream master ports onto one downstream port,
// with request locking, RR/fixed priority, and in-order response routing via an ID FIFO.
module ysyx_22050710_sram_arbiter
  import ysyx_22050710_sram_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned SRAM_ADDR_WD    = 32,
  parameter int unsigned SRAM_WMASK_WD   = 8,
  parameter int unsigned SRAM_DATA_WD    = 64,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned PRIO_MODE       = 0
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [NUM_CH-1:0]                 i_s_req,
  input  logic [NUM_CH-1:0]                 i_s_op,
  input  logic [2*NUM_CH-1:0]               i_s_size,
  input  logic [NUM_CH*SRAM_ADDR_WD-1:0]    i_s_addr,
  input  logic [NUM_CH*SRAM_WMASK_WD-1:0]   i_s_wstrb,
  input  logic [NUM_CH*SRAM_DATA_WD-1:0]    i_s_wdata,
  output logic [NUM_CH-1:0]                 o_s_addr_ok,
  output logic [NUM_CH-1:0]                 o_s_data_ok,
  output logic [SRAM_DATA_WD-1:0]           o_s_rdata,
  output logic                              o_m_req,
  output logic                              o_m_op,
  output logic [1:0]                        o_m_size,
  output logic [SRAM_ADDR_WD-1:0]           o_m_addr,
  output logic [SRAM_WMASK_WD-1:0]          o_m_wstrb,
  output logic [SRAM_DATA_WD-1:0]           o_m_wdata,
  input  logic                              i_m_addr_ok,
  input  logic                              i_m_data_ok,
  input  logic [SRAM_DATA_WD-1:0]           i_m_rdata
);

  localparam int unsigned     CH_W    = ch_id_wd(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [CH_W-1:0]   r_lock_ch;
  logic [CH_W-1:0]   r_last_grant;
  logic [CH_W-1:0]   w_grant;
  logic [CH_W-1:0]   w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_m_req;
  logic              w_hs;
  logic              w_stall;
  logic              w_pop;

  logic [SRAM_ADDR_WD-1:0]  w_addr_ch  [NUM_CH];
  logic [SRAM_WMASK_WD-1:0] w_wstrb_ch [NUM_CH];
  logic [SRAM_DATA_WD-1:0]  w_wdata_ch [NUM_CH];
  logic [1:0]               w_size_ch  [NUM_CH];

  function automatic int unsigned rr_idx(input logic [CH_W-1:0] base, input int unsigned off);
    return (int'(base) + off) % NUM_CH;
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_addr_ch[g]  = i_s_addr[g*SRAM_ADDR_WD +: SRAM_ADDR_WD];
    assign w_wstrb_ch[g] = i_s_wstrb[g*SRAM_WMASK_WD +: SRAM_WMASK_WD];
    assign w_wdata_ch[g] = i_s_wdata[g*SRAM_DATA_WD +: SRAM_DATA_WD];
    assign w_size_ch[g]  = i_s_size[g*2 +: 2];
  end

  // Grant select: later loop iterations override earlier ones, so the
  // highest-priority candidate is visited last.
  always_comb begin
    w_grant = '0;
    if (r_state == ARB_LOCKED) begin
      w_grant = r_lock_ch;
    end else if (PRIO_MODE != 0) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (i_s_req[CH_W'(i)]) w_grant = CH_W'(i);
      end
    end else begin
      for (int unsigned off = NUM_CH; off >= 1; off--) begin
        if (i_s_req[CH_W'(rr_idx(r_last_grant, off))]) w_grant = CH_W'(rr_idx(r_last_grant, off));
      end
    end
  end

  assign w_m_req = i_rst_n && !w_full && i_s_req[w_grant];
  assign w_hs    = w_m_req && i_m_addr_ok;
  assign w_stall = w_m_req && !i_m_addr_ok;
  assign w_pop   = i_rst_n && i_m_data_ok && !w_empty;

  assign o_m_req     = w_m_req;
  assign o_m_op      = i_s_op[w_grant];
  assign o_m_size    = w_size_ch[w_grant];
  assign o_m_addr    = w_addr_ch[w_grant];
  assign o_m_wstrb   = w_wstrb_ch[w_grant];
  assign o_m_wdata   = w_wdata_ch[w_grant];
  assign o_s_addr_ok = w_hs  ? (NUM_CH'(1) << w_grant) : '0;
  assign o_s_data_ok = w_pop ? (NUM_CH'(1) << w_head)  : '0;
  assign o_s_rdata   = i_m_rdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ARB_OPEN;
      r_lock_ch    <= '0;
      r_last_grant <= LAST_CH;
    end else begin
      r_state <= w_state_nxt;
      if (w_stall) r_lock_ch    <= w_grant;
      if (w_hs)    r_last_grant <= w_grant;
    end
  end

  // Lock holds the grant on a stalled request until it is accepted.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_OPEN:   if (w_stall) w_state_nxt = ARB_LOCKED;
      ARB_LOCKED: if (w_hs)    w_state_nxt = ARB_OPEN;
      default:    w_state_nxt = ARB_OPEN;
    endcase
  end

  ysyx_22050710_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (CH_W)
  ) u_id_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_hs),
    .i_pop   (w_pop),
    .i_wdata (w_grant),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  a_no_orphan_data_ok: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_m_data_ok |-> !w_empty)
    else $error("sram_arbiter: data_ok with no request outstanding");

endmodule

// File: tb/tb_ysyx_22050710_sram_arbiter.sv
// Scoreboard bench: round-robin and fixed-priority arbiters share one stimulus stream;
// expected handshakes are queued by the stimulus and checked by a negedge monitor.
module tb_ysyx_22050710_sram_arbiter;

  localparam int unsigned NCH = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned MW  = 8;
  localparam int unsigned DW  = 64;

  typedef struct {
    int          ch;
    logic [63:0] rdata;
  } rsp_t;

  logic clk;
  logic rst_n;
  logic [NCH-1:0]    s_req, s_op;
  logic [2*NCH-1:0]  s_size;
  logic [NCH*AW-1:0] s_addr;
  logic [NCH*MW-1:0] s_wstrb;
  logic [NCH*DW-1:0] s_wdata;
  logic              m_addr_ok, m_data_ok;
  logic [DW-1:0]     m_rdata;

  logic [NCH-1:0] rr_aok, rr_dok, fp_aok, fp_dok;
  logic [DW-1:0]  rr_rdata, fp_rdata, rr_wdata, fp_wdata;
  logic           rr_req, rr_op, fp_req, fp_op;
  logic [1:0]     rr_size, fp_size;
  logic [AW-1:0]  rr_addr, fp_addr;
  logic [MW-1:0]  rr_wstrb, fp_wstrb;

  int   q_acc_rr[$];
  int   q_acc_fp[$];
  rsp_t q_rsp_rr[$];
  rsp_t q_rsp_fp[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ysyx_22050710_sram_arbiter #(.PRIO_MODE(0)) u_dut_rr (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_s_req(s_req), .i_s_op(s_op), .i_s_size(s_size), .i_s_addr(s_addr),
    .i_s_wstrb(s_wstrb), .i_s_wdata(s_wdata),
    .o_s_addr_ok(rr_aok), .o_s_data_ok(rr_dok), .o_s_rdata(rr_rdata),
    .o_m_req(rr_req), .o_m_op(rr_op), .o_m_size(rr_size), .o_m_addr(rr_addr),
    .o_m_wstrb(rr_wstrb), .o_m_wdata(rr_wdata),
    .i_m_addr_ok(m_addr_ok), .i_m_data_ok(m_data_ok), .i_m_rdata(m_rdata)
  );

  ysyx_22050710_sram_arbiter #(.PRIO_MODE(1)) u_dut_fp (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_s_req(s_req), .i_s_op(s_op), .i_s_size(s_size), .i_s_addr(s_addr),
    .i_s_wstrb(s_wstrb), .i_s_wdata(s_wdata),
    .o_s_addr_ok(fp_aok), .o_s_data_ok(fp_dok), .o_s_rdata(fp_rdata),
    .o_m_req(fp_req), .o_m_op(fp_op), .o_m_size(fp_size), .o_m_addr(fp_addr),
    .o_m_wstrb(fp_wstrb), .o_m_wdata(fp_wdata),
    .i_m_addr_ok(m_addr_ok), .i_m_data_ok(m_data_ok), .i_m_rdata(m_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ch_addr(input int ch);
    return (ch == 1) ? 32'h8000_1000 : 32'h8000_0000;
  endfunction

  function automatic logic [1:0] ch_size(input int ch);
    return (ch == 1) ? 2'd2 : 2'd3;
  endfunction

  function automatic logic [NCH-1:0] onehot(input int ch);
    return NCH'(1) << ch;
  endfunction

  // Monitor: every handshake the DUTs present must match the next queued expectation.
  always @(negedge clk) begin
    int   a;
    rsp_t r;
    if (|rr_aok) begin
      if (q_acc_rr.size() == 0) chk("rr_aok_unexpected", 64'(rr_aok), 64'd0);
      else begin
        a = q_acc_rr.pop_front();
        chk("rr_aok", 64'(rr_aok), 64'(onehot(a)));
        chk("rr_addr", 64'(rr_addr), 64'(ch_addr(a)));
        chk("rr_op", 64'(rr_op), 64'(a == 1));
        chk("rr_size", 64'(rr_size), 64'(ch_size(a)));
      end
    end
    if (|fp_aok) begin
      if (q_acc_fp.size() == 0) chk("fp_aok_unexpected", 64'(fp_aok), 64'd0);
      else begin
        a = q_acc_fp.pop_front();
        chk("fp_aok", 64'(fp_aok), 64'(onehot(a)));
        chk("fp_addr", 64'(fp_addr), 64'(ch_addr(a)));
      end
    end
    if (|rr_dok) begin
      if (q_rsp_rr.size() == 0) chk("rr_dok_unexpected", 64'(rr_dok), 64'd0);
      else begin
        r = q_rsp_rr.pop_front();
        chk("rr_dok", 64'(rr_dok), 64'(onehot(r.ch)));
        chk("rr_rdata", rr_rdata, r.rdata);
      end
    end
    if (|fp_dok) begin
      if (q_rsp_fp.size() == 0) chk("fp_dok_unexpected", 64'(fp_dok), 64'd0);
      else begin
        r = q_rsp_fp.pop_front();
        chk("fp_dok", 64'(fp_dok), 64'(onehot(r.ch)));
        chk("fp_rdata", fp_rdata, r.rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NCH-1:0] req, input logic aok, input logic dok,
                       input logic [63:0] rd);
    s_req     = req;
    m_addr_ok = aok;
    m_data_ok = dok;
    m_rdata   = rd;
  endtask

  task automatic exp_acc(input int rr_ch, input int fp_ch);
    q_acc_rr.push_back(rr_ch);
    q_acc_fp.push_back(fp_ch);
  endtask

  task automatic exp_rsp(input int rr_ch, input int fp_ch, input logic [63:0] rd);
    rsp_t r;
    r.rdata = rd;
    r.ch = rr_ch;
    q_rsp_rr.push_back(r);
    r.ch = fp_ch;
    q_rsp_fp.push_back(r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive('0, 1'b0, 1'b0, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    s_op    = 2'b10;
    s_size  = {2'd2, 2'd3};
    s_addr  = {32'h8000_1000, 32'h8000_0000};
    s_wstrb = {8'h0F, 8'h00};
    s_wdata = {64'h1111_2222_3333_4444, 64'h0};
    drive(2'b11, 1'b1, 1'b1, 64'h55);
    @(negedge clk);
    chk("rst_rr_req", 64'(rr_req), 64'd0);
    chk("rst_fp_req", 64'(fp_req), 64'd0);
    chk("rst_rr_aok", 64'(rr_aok), 64'd0);
    chk("rst_rr_dok", 64'(rr_dok), 64'd0);
    do_reset();

    // single read, response two cycles after acceptance
    drive(2'b01, 1'b1, 1'b0, 64'd0); exp_acc(0, 0); tick();
    drive(2'b00, 1'b0, 1'b0, 64'd0); tick();
    drive(2'b00, 1'b0, 1'b1, 64'hDEAD_BEEF); exp_rsp(0, 0, 64'hDEAD_BEEF); tick();
    drive(2'b00, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    chk("t1_dok_single_pulse", 64'(rr_dok), 64'd0);
    tick();

    // both channels back-to-back
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive((k < 4) ? 2'b11 : 2'b00, k < 4, k >= 1, 64'(32'h100 + k));
      if (k < 4) exp_acc(k % 2, 0);
      if (k >= 1) exp_rsp((k - 1) % 2, 0, 64'(32'h100 + k));
      tick();
    end

    // lock holds ch1 while ch0 joins
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive((k == 0) ? 2'b10 : 2'b11, k == 3, 1'b0, 64'd0);
      if (k == 3) exp_acc(1, 1);
      @(negedge clk);
      chk("t3_rr_addr_locked", 64'(rr_addr), 64'(ch_addr(1)));
      chk("t3_fp_addr_locked", 64'(fp_addr), 64'(ch_addr(1)));
      tick();
    end
    drive(2'b01, 1'b1, 1'b0, 64'd0); exp_acc(0, 0); tick();
    drive(2'b00, 1'b0, 1'b1, 64'h300); exp_rsp(1, 1, 64'h300); tick();
    drive(2'b00, 1'b0, 1'b1, 64'h301); exp_rsp(0, 0, 64'h301); tick();

    // full FIFO blocks issue, including the cycle of a pop
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, 1'b1, 1'b0, 64'd0); exp_acc(0, 0); tick();
    end
    drive(2'b01, 1'b1, 1'b0, 64'd0);
    @(negedge clk);
    chk("t4_rr_req_full", 64'(rr_req), 64'd0);
    chk("t4_fp_req_full", 64'(fp_req), 64'd0);
    tick();
    drive(2'b01, 1'b1, 1'b1, 64'h400); exp_rsp(0, 0, 64'h400);
    @(negedge clk);
    chk("t4_rr_req_full_pop", 64'(rr_req), 64'd0);
    tick();
    drive(2'b01, 1'b1, 1'b0, 64'd0); exp_acc(0, 0);
    @(negedge clk);
    chk("t4_rr_req_resume", 64'(rr_req), 64'd1);
    tick();
    for (int j = 0; j < 4; j++) begin
      drive(2'b00, 1'b0, 1'b1, 64'(32'h401 + j)); exp_rsp(0, 0, 64'(32'h401 + j)); tick();
    end

    // in-order routing of mixed-channel responses
    do_reset();
    drive(2'b01, 1'b1, 1'b0, 64'd0); exp_acc(0, 0); tick();
    drive(2'b10, 1'b1, 1'b0, 64'd0); exp_acc(1, 1); tick();
    drive(2'b01, 1'b1, 1'b0, 64'd0); exp_acc(0, 0); tick();
    for (int j = 0; j < 3; j++) begin
      drive(2'b00, 1'b0, 1'b1, 64'(32'h500 + j)); exp_rsp(j % 2, j % 2, 64'(32'h500 + j)); tick();
    end

    // reset with requests in flight
    do_reset();
    drive(2'b01, 1'b1, 1'b0, 64'd0); exp_acc(0, 0); tick();
    drive(2'b10, 1'b1, 1'b0, 64'd0); exp_acc(1, 1); tick();
    rst_n = 1'b0;
    drive(2'b11, 1'b1, 1'b1, 64'h600);
    @(negedge clk);
    chk("t6_rr_req_in_rst", 64'(rr_req), 64'd0);
    chk("t6_rr_aok_in_rst", 64'(rr_aok), 64'd0);
    chk("t6_rr_dok_in_rst", 64'(rr_dok), 64'd0);
    chk("t6_fp_dok_in_rst", 64'(fp_dok), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    drive(2'b11, 1'b1, 1'b0, 64'd0); exp_acc(0, 0); tick();
    drive(2'b11, 1'b1, 1'b0, 64'd0); exp_acc(1, 0); tick();
    drive(2'b00, 1'b0, 1'b1, 64'h610); exp_rsp(0, 0, 64'h610); tick();
    drive(2'b00, 1'b0, 1'b1, 64'h611); exp_rsp(1, 0, 64'h611); tick();
    drive(2'b00, 1'b0, 1'b0, 64'd0);
    tick();

    chk("end_q_acc_rr_empty", 64'(q_acc_rr.size()), 64'd0);
    chk("end_q_acc_fp_empty", 64'(q_acc_fp.size()), 64'd0);
    chk("end_q_rsp_rr_empty", 64'(q_rsp_rr.size()), 64'd0);
    chk("end_q_rsp_fp_empty", 64'(q_rsp_fp.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
